// File: rtl/digit_scan.sv
// Time-multiplexed seven-segment hex driver with double-buffered, frame-aligned loads.
// Latency: 1 cycle from scan index/display buffer to registered pin outputs.
// No backpressure: loads are accepted every cycle and the last load before a frame boundary wins.
module digit_scan #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digit_scani_data,
    input  logic [DIGITS-1:0]     digit_scani_dp,
    input  logic                  digit_scani_load,
    input  logic                  digit_scani_blank_lz,
    input  logic                  digit_scani_en,
    output logic [6:0]            digit_scano_seg,
    output logic                  digit_scano_dp,
    output logic [DIGITS-1:0]     digit_scano_sel,
    output logic                  digit_scano_frame
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]     PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_POL   = {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] SEL_POL   = {DIGITS{ACTIVE_LOW}};

    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] disp_dat;
    logic [DIGITS-1:0]   disp_dp;
    logic [4*DIGITS-1:0] pend_dat;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_vld;

    logic                tick;
    logic                boundary;
    logic [3:0]          cur_nib;
    logic [6:0]          seg_code;
    logic                all_zero;
    logic                lz_blank;
    logic [DIGITS-1:0]   sel_code;

    assign tick     = (presc == PRESC_MAX);
    assign boundary = tick && (idx == IDX_MAX);
    assign cur_nib  = disp_dat[{idx, 2'b00} +: 4];
    assign sel_code = DIGITS'(1) << idx;

    always_comb begin
        seg_code = 7'h00;
        case (cur_nib)
            4'h0: seg_code = 7'h3f;
            4'h1: seg_code = 7'h06;
            4'h2: seg_code = 7'h5b;
            4'h3: seg_code = 7'h4f;
            4'h4: seg_code = 7'h66;
            4'h5: seg_code = 7'h6d;
            4'h6: seg_code = 7'h7d;
            4'h7: seg_code = 7'h07;
            4'h8: seg_code = 7'h7f;
            4'h9: seg_code = 7'h6f;
            4'ha: seg_code = 7'h77;
            4'hb: seg_code = 7'h7c;
            4'hc: seg_code = 7'h39;
            4'hd: seg_code = 7'h5e;
            4'he: seg_code = 7'h79;
            4'hf: seg_code = 7'h71;
            default: seg_code = 7'h00;
        endcase
    end

    // Walk from the top digit down; a digit is a leading zero while every nibble at or above it is zero.
    always_comb begin
        all_zero = 1'b1;
        lz_blank = 1'b0;
        for (int j = DIGITS - 1; j >= 0; j--) begin
            all_zero = all_zero & (disp_dat[4*j +: 4] == 4'h0);
            if (j != 0 && IW'(j) == idx) begin
                lz_blank = all_zero;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
        end
    end

    // A load on the boundary itself bypasses the pending buffer so it lands in the frame starting now.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_dat <= '0;
            disp_dp  <= '0;
            pend_dat <= '0;
            pend_dp  <= '0;
            pend_vld <= 1'b0;
        end else if (boundary) begin
            if (digit_scani_load) begin
                disp_dat <= digit_scani_data;
                disp_dp  <= digit_scani_dp;
            end else if (pend_vld) begin
                disp_dat <= pend_dat;
                disp_dp  <= pend_dp;
            end
            pend_vld <= 1'b0;
        end else if (digit_scani_load) begin
            pend_dat <= digit_scani_data;
            pend_dp  <= digit_scani_dp;
            pend_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_scano_seg   <= SEG_POL;
            digit_scano_dp    <= ACTIVE_LOW;
            digit_scano_sel   <= SEL_POL;
            digit_scano_frame <= 1'b0;
        end else begin
            digit_scano_frame <= boundary;
            if (digit_scani_en) begin
                digit_scano_seg <= ((digit_scani_blank_lz && lz_blank) ? 7'h00 : seg_code) ^ SEG_POL;
                digit_scano_dp  <= disp_dp[idx] ^ ACTIVE_LOW;
                digit_scano_sel <= sel_code ^ SEL_POL;
            end else begin
                digit_scano_seg <= SEG_POL;
                digit_scano_dp  <= ACTIVE_LOW;
                digit_scano_sel <= SEL_POL;
            end
        end
    end

endmodule
